// File: rtl/elevator_pkg.sv
// Shared constants and types for the hall-call dispatcher and the fleet logic around it.
package elevator_pkg;

  localparam int N_FLOORS            = 8;
  localparam int FLOOR_W             = 3;
  localparam int N_CARS              = 3;
  localparam int ACK_TIMEOUT_DEFAULT = 4;
  localparam int TIMER_W             = 4;

  typedef logic [FLOOR_W-1:0] floor_t;
  typedef logic [1:0]         car_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } disp_state_e;

  function automatic floor_t floor_dist(input floor_t a, input floor_t b);
    return (a >= b) ? floor_t'(a - b) : floor_t'(b - a);
  endfunction

endpackage

// File: rtl/elevator_dispatcher_nearest_car_sel.sv
// Picks the eligible car closest to a target floor; ties resolve to the lowest car index.
module nearest_car_sel
  import elevator_pkg::*;
(
  input  floor_t              i_target,
  input  floor_t              i_car_floor0,
  input  floor_t              i_car_floor1,
  input  floor_t              i_car_floor2,
  input  logic [N_CARS-1:0]   i_eligible,
  output car_idx_t            o_car,
  output logic                o_found
);

  floor_t   w_floors [N_CARS];
  floor_t   w_dist;
  floor_t   w_best;
  car_idx_t w_car;
  logic     w_found;

  assign w_floors[0] = i_car_floor0;
  assign w_floors[1] = i_car_floor1;
  assign w_floors[2] = i_car_floor2;

  // Strict less-than keeps the earliest (lowest-index) car on equal distance.
  always_comb begin
    w_dist  = '0;
    w_best  = '0;
    w_car   = '0;
    w_found = 1'b0;
    for (int c = 0; c < N_CARS; c++) begin
      w_dist = floor_dist(w_floors[c], i_target);
      if (i_eligible[c] && (!w_found || (w_dist < w_best))) begin
        w_found = 1'b1;
        w_best  = w_dist;
        w_car   = car_idx_t'(c);
      end
    end
  end

  assign o_car   = w_car;
  assign o_found = w_found;

endmodule

// File: rtl/elevator_dispatcher.sv
// Hall-call dispatcher: latches calls, round-robins over pending floors and offers each to the
// nearest idle car. Offer handshake: a car's dispatch_valid stays high with dispatch_floor stable
// until that car raises dispatch_ack (accepted), drops car_idle, or the ack timeout expires.
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                call_valid,
  input  floor_t              call_floor,
  input  floor_t              car_floor1,
  input  floor_t              car_floor2,
  input  floor_t              car_floor3,
  input  logic                car_idle1,
  input  logic                car_idle2,
  input  logic                car_idle3,
  input  logic                dispatch_ack1,
  input  logic                dispatch_ack2,
  input  logic                dispatch_ack3,
  output logic                dispatch_valid1,
  output logic                dispatch_valid2,
  output logic                dispatch_valid3,
  output floor_t              dispatch_floor,
  output logic [N_FLOORS-1:0] pending,
  output disp_state_e         dbg_state
);

  disp_state_e         r_state;
  logic [N_FLOORS-1:0] r_pending;
  logic [N_CARS-1:0]   r_valid;
  logic [N_CARS-1:0]   r_mask;
  floor_t              r_floor;
  floor_t              r_rr_ptr;
  logic [TIMER_W-1:0]  r_timer;

  logic [N_CARS-1:0]   w_idle;
  logic [N_CARS-1:0]   w_ack;
  logic [N_CARS-1:0]   w_eligible;
  logic [N_FLOORS-1:0] w_call_bit;
  logic [N_FLOORS-1:0] w_clear_bit;
  logic [N_FLOORS-1:0] w_pending_next;
  logic                w_acked;
  logic                w_offer_lost;
  logic                w_expired;
  logic                w_scan_found;
  floor_t              w_scan_floor;
  floor_t              w_scan_idx;
  car_idx_t            w_sel_car;
  logic                w_car_found;

  assign w_idle       = {car_idle3, car_idle2, car_idle1};
  assign w_ack        = {dispatch_ack3, dispatch_ack2, dispatch_ack1};
  assign w_eligible   = w_idle & ~r_mask;
  assign w_acked      = (r_state == OFFER) && |(r_valid & w_ack);
  assign w_offer_lost = !(|(r_valid & w_idle));
  assign w_expired    = (r_timer == TIMER_W'(ACK_TIMEOUT - 1));

  // Clear wins over a same-edge call, so a call merging into the accepted floor disappears.
  always_comb begin
    w_call_bit  = '0;
    w_clear_bit = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      w_call_bit[i]  = call_valid && (call_floor == floor_t'(i));
      w_clear_bit[i] = w_acked && (r_floor == floor_t'(i));
    end
    w_pending_next = (r_pending | w_call_bit) & ~w_clear_bit;
  end

  // Scan upward from rr_ptr+1; floor_t arithmetic wraps because N_FLOORS is a power of two.
  always_comb begin
    w_scan_found = 1'b0;
    w_scan_floor = '0;
    w_scan_idx   = '0;
    for (int k = 1; k <= N_FLOORS; k++) begin
      w_scan_idx = r_rr_ptr + floor_t'(k);
      if (!w_scan_found && r_pending[w_scan_idx]) begin
        w_scan_found = 1'b1;
        w_scan_floor = w_scan_idx;
      end
    end
  end

  nearest_car_sel u_nearest_car_sel (
    .i_target     (w_scan_floor),
    .i_car_floor0 (car_floor1),
    .i_car_floor1 (car_floor2),
    .i_car_floor2 (car_floor3),
    .i_eligible   (w_eligible),
    .o_car        (w_sel_car),
    .o_found      (w_car_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_valid   <= '0;
      r_mask    <= '0;
      r_floor   <= '0;
      r_rr_ptr  <= floor_t'(N_FLOORS - 1);
      r_timer   <= '0;
    end else begin
      r_pending <= w_pending_next;
      case (r_state)
        IDLE: begin
          // A timed-out car sits out exactly one selection, then becomes eligible again.
          r_mask <= '0;
          if (w_scan_found && w_car_found) begin
            r_valid <= N_CARS'(1) << w_sel_car;
            r_floor <= w_scan_floor;
            r_timer <= '0;
            r_state <= OFFER;
          end
        end
        OFFER: begin
          if (w_acked) begin
            r_valid  <= '0;
            r_rr_ptr <= r_floor;
            r_state  <= IDLE;
          end else if (w_expired || w_offer_lost) begin
            r_valid <= '0;
            r_mask  <= r_valid;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dispatch_valid1 = r_valid[0];
  assign dispatch_valid2 = r_valid[1];
  assign dispatch_valid3 = r_valid[2];
  assign dispatch_floor  = r_floor;
  assign pending         = r_pending;
  assign dbg_state       = r_state;

endmodule
